vnarrow_merge: RTL

//  Write-combining stage directly downstream of the narrowing unit. Narrowing emits half-width results

---
 rtl/vnarrow_merge_pkg.sv | 35 +++
 rtl/vnarrow_merge_if.sv | 31 +++
 rtl/vnarrow_merge_byte_merge.sv | 25 ++
 rtl/vnarrow_merge.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/vnarrow_merge_pkg.sv
// Shared definitions for the narrowing write-combiner: FSM states, half-beat byte-enable masks
// and the beat classifier used to decide whether a beat can pair with a held half.
package vnarrow_merge_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BC_ZERO = 2'd0,
    BC_HALF = 2'd1,
    BC_FULL = 2'd2
  } beat_class_e;

  localparam logic [7:0] LO_HALF_BE = 8'h0F;
  localparam logic [7:0] HI_HALF_BE = 8'hF0;

  // A beat is FULL when both halves carry enabled bytes, HALF when exactly one does.
  function automatic beat_class_e beat_class(input logic [7:0] be);
    logic loAny;
    logic hiAny;
    loAny = |(be & LO_HALF_BE);
    hiAny = |(be & HI_HALF_BE);
    if (!loAny && !hiAny) begin
      return BC_ZERO;
    end else if (loAny && hiAny) begin
      return BC_FULL;
    end else begin
      return BC_HALF;
    end
  endfunction

endpackage

// File: rtl/vnarrow_merge_if.sv
// Beat-in / write-out bundle between the narrowing unit, this combiner and the VRF write port.
// The master drives narrowed beats and observes writes; the slave is the combiner itself.
interface vnarrow_merge_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int BE_WIDTH   = 8
);

  logic [DATA_WIDTH-1:0] in_vec;
  logic [BE_WIDTH-1:0]   in_be;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  in_valid;
  logic                  in_last;

  logic [DATA_WIDTH-1:0] out_vec;
  logic [BE_WIDTH-1:0]   out_be;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_valid;
  logic                  out_merged;

  modport master (
    output in_vec, in_be, in_addr, in_valid, in_last,
    input  out_vec, out_be, out_addr, out_valid, out_merged
  );

  modport slave (
    input  in_vec, in_be, in_addr, in_valid, in_last,
    output out_vec, out_be, out_addr, out_valid, out_merged
  );

endinterface

// File: rtl/vnarrow_merge_byte_merge.sv
// Combinational byte-wise merge: bytes enabled in beat A win, all other bytes come from beat B.
// The merged enable is the union of both enables.
module v_byte_merge #(
  parameter int BE_WIDTH = 8
) (
  input  logic [BE_WIDTH*8-1:0] aVec_i,
  input  logic [BE_WIDTH-1:0]   aBe_i,
  input  logic [BE_WIDTH*8-1:0] bVec_i,
  input  logic [BE_WIDTH-1:0]   bBe_i,
  output logic [BE_WIDTH*8-1:0] mergedVec_o,
  output logic [BE_WIDTH-1:0]   mergedBe_o
);

  always_comb begin
    mergedVec_o = bVec_i;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (aBe_i[i]) begin
        mergedVec_o[i*8 +: 8] = aVec_i[i*8 +: 8];
      end
    end
  end

  assign mergedBe_o = aBe_i | bBe_i;

endmodule

// File: rtl/vnarrow_merge.sv
// Write-combiner behind the narrowing unit: pairs lower/upper half beats aimed at the same VRF
// address into one full-width write, flushing a lone half on mismatch, last or idle timeout.
module vnarrow_merge
  import vnarrow_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int IDLE_FLUSH = 16
) (
  input  logic            clk,
  input  logic            rst,
  vnarrow_merge_if.slave  bus
);

  localparam int IDLE_W = (IDLE_FLUSH > 1) ? $clog2(IDLE_FLUSH) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_FLUSH - 1);

  state_e                state_q, state_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic [DATA_WIDTH-1:0] holdVec_q;
  logic [BE_WIDTH-1:0]   holdBe_q;
  logic [ADDR_WIDTH-1:0] holdAddr_q;

  logic [DATA_WIDTH-1:0] outVec_q;
  logic [BE_WIDTH-1:0]   outBe_q;
  logic [ADDR_WIDTH-1:0] outAddr_q;
  logic                  outValid_q;
  logic                  outMerged_q;

  beat_class_e           beatCls;
  logic                  isZero;
  logic                  pairMatch;
  logic                  idleHit;
  logic                  capture;
  logic                  emitHold;
  logic                  emitMerged;
  logic [DATA_WIDTH-1:0] mergedVec;
  logic [BE_WIDTH-1:0]   mergedBe;

  v_byte_merge #(
    .BE_WIDTH (BE_WIDTH)
  ) u_byte_merge (
    .aVec_i      (bus.in_vec),
    .aBe_i       (bus.in_be),
    .bVec_i      (holdVec_q),
    .bBe_i       (holdBe_q),
    .mergedVec_o (mergedVec),
    .mergedBe_o  (mergedBe)
  );

  assign beatCls   = beat_class(bus.in_be);
  assign isZero    = (beatCls == BC_ZERO);
  assign pairMatch = (bus.in_addr == holdAddr_q) && ((bus.in_be & holdBe_q) == '0)
                     && (beatCls == BC_HALF);
  assign idleHit   = (IDLE_FLUSH != 0) && (idle_q == IDLE_LAST);

  // Next-state and write decision; a capture always overwrites the hold registers because any
  // previously held half is emitted in the same cycle.
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    emitHold   = 1'b0;
    emitMerged = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (bus.in_valid && !isZero) begin
          capture = 1'b1;
          state_d = (beatCls == BC_HALF && !bus.in_last) ? ST_HELD : ST_FLUSH;
        end
      end
      ST_HELD: begin
        if (bus.in_valid) begin
          if (pairMatch) begin
            emitMerged = 1'b1;
            state_d    = ST_EMPTY;
          end else if (!isZero) begin
            emitHold = 1'b1;
            capture  = 1'b1;
            state_d  = (bus.in_last || beatCls == BC_FULL) ? ST_FLUSH : ST_HELD;
          end else if (bus.in_last) begin
            emitHold = 1'b1;
            state_d  = ST_EMPTY;
          end
        end else if (idleHit) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        emitHold = 1'b1;
        state_d  = ST_EMPTY;
        if (bus.in_valid && !isZero) begin
          capture = 1'b1;
          state_d = (beatCls == BC_HALF && !bus.in_last) ? ST_HELD : ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // The idle counter only advances while a half sits in HELD with no traffic arriving.
  always_comb begin
    idle_d = '0;
    if (IDLE_FLUSH != 0 && state_q == ST_HELD && state_d == ST_HELD && !bus.in_valid) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      idle_q      <= '0;
      holdVec_q   <= '0;
      holdBe_q    <= '0;
      holdAddr_q  <= '0;
      outVec_q    <= '0;
      outBe_q     <= '0;
      outAddr_q   <= '0;
      outValid_q  <= 1'b0;
      outMerged_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      outValid_q  <= emitHold | emitMerged;
      outMerged_q <= emitMerged;
      if (emitMerged) begin
        outVec_q  <= mergedVec;
        outBe_q   <= mergedBe;
        outAddr_q <= holdAddr_q;
      end else if (emitHold) begin
        outVec_q  <= holdVec_q;
        outBe_q   <= holdBe_q;
        outAddr_q <= holdAddr_q;
      end else begin
        outVec_q  <= '0;
        outBe_q   <= '0;
        outAddr_q <= '0;
      end
      if (capture) begin
        holdVec_q  <= bus.in_vec;
        holdBe_q   <= bus.in_be;
        holdAddr_q <= bus.in_addr;
      end
    end
  end

  assign bus.out_vec    = outVec_q;
  assign bus.out_be     = outBe_q;
  assign bus.out_addr   = outAddr_q;
  assign bus.out_valid  = outValid_q;
  assign bus.out_merged = outMerged_q;

endmodule
